// File: rtl/ccd_fmt_pkg.sv
// Shared definitions for the CCD line formatter: parameter defaults, the
// line-sequencing FSM state type and the FIFO word layout {tuser, tlast, data}.
package ccd_fmt_pkg;

    localparam int DEF_D_WIDTH   = 12;
    localparam int DEF_SAMP_NUM  = 2088;
    localparam int DEF_OB_START  = 16;
    localparam int DEF_OB_LOG2   = 3;
    localparam int DEF_ACT_START = 32;
    localparam int DEF_ACT_LEN   = 2048;
    localparam int DEF_FIFO_LOG2 = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LINE,
        ST_DARK,
        ST_ACTIVE,
        ST_TAIL
    } fmt_state_t;

    // FIFO word is {tuser, tlast, data[d_width-1:0]}.
    function automatic int word_width(input int d_width);
        return d_width + 2;
    endfunction

    function automatic int tlast_bit(input int d_width);
        return d_width;
    endfunction

    function automatic int tuser_bit(input int d_width);
        return d_width + 1;
    endfunction

endpackage

// File: rtl/ccd_fmt_fifo.sv
// Synchronous first-word-fall-through FIFO: the head word is always visible
// on rd_data while empty is low. Writes while full and reads while empty
// are ignored.
module ccd_fmt_fifo #(
    parameter int WIDTH = 14,
    parameter int LOG2  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << LOG2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG2:0]    wr_ptr;
    logic [LOG2:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[LOG2] != rd_ptr[LOG2]) &&
                     (wr_ptr[LOG2-1:0] == rd_ptr[LOG2-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[LOG2-1:0]];

    // Read/write pointer advance.
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // independent of statement order inside or across blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    // NOTE: the array is deliberately not reset; the pointers alone define
    // which entries are valid, so it can map onto plain RAM/LUT storage.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[LOG2-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ccd_line_formatter.sv
// CCD line formatter: detects line starts on sh, measures the optical-black
// dark level of each line, subtracts it from the active pixels and streams
// them out over AXI-Stream through a small FWFT FIFO.
module ccd_line_formatter
    import ccd_fmt_pkg::*;
#(
    parameter int D_WIDTH   = DEF_D_WIDTH,
    parameter int SAMP_NUM  = DEF_SAMP_NUM,
    parameter int OB_START  = DEF_OB_START,
    parameter int OB_LOG2   = DEF_OB_LOG2,
    parameter int ACT_START = DEF_ACT_START,
    parameter int ACT_LEN   = DEF_ACT_LEN,
    parameter int FIFO_LOG2 = DEF_FIFO_LOG2
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               en,
    input  logic               clr_flags,
    input  logic               sh,
    input  logic [D_WIDTH-1:0] s_tdata,
    input  logic               s_tvalid,
    output logic [D_WIDTH-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    output logic [D_WIDTH-1:0] dark_level,
    output logic [15:0]        line_cnt,
    output logic               ovf_flag,
    output logic               short_flag
);

    localparam int IDX_W  = $clog2(SAMP_NUM);
    localparam int ACC_W  = D_WIDTH + OB_LOG2;
    localparam int WORD_W = word_width(D_WIDTH);

    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(SAMP_NUM - 1);
    localparam logic [IDX_W-1:0] OB_FIRST  = IDX_W'(OB_START);
    localparam logic [IDX_W-1:0] OB_END    = IDX_W'(OB_START + (1 << OB_LOG2));
    localparam logic [IDX_W-1:0] DARK_LAST = IDX_W'(ACT_START - 1);
    localparam logic [IDX_W-1:0] ACT_FIRST = IDX_W'(ACT_START);
    localparam logic [IDX_W-1:0] ACT_LAST  = IDX_W'(ACT_START + ACT_LEN - 1);

    fmt_state_t         state, state_nxt;
    logic               sh_q, sh_q_d, sh_rise;
    logic [IDX_W-1:0]   pix_cnt;
    logic [ACC_W-1:0]   acc, acc_sum, acc_total;
    logic               acc_clr, acc_add, dark_ld, act_take, short_set;
    logic               s1_valid, s1_user, s1_last;
    logic [D_WIDTH-1:0] s1_data;
    logic [D_WIDTH:0]   diff;
    logic [D_WIDTH-1:0] clamped;
    logic [WORD_W-1:0]  wr_word, rd_word;
    logic               fifo_full, fifo_empty, fifo_wr, ovf_set;

    // sh is registered once; its registered copy is compared with its past value.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sh_q   <= 1'b0;
            sh_q_d <= 1'b0;
        end else begin
            sh_q   <= sh;
            sh_q_d <= sh_q;
        end
    end
    assign sh_rise = sh_q && !sh_q_d;

    // Sample index: a pixel arriving with the sh edge is index 0 of the new line.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)                          pix_cnt <= '0;
        else if (sh_rise)                     pix_cnt <= s_tvalid ? IDX_W'(1) : '0;
        else if (s_tvalid && pix_cnt != IDX_MAX) pix_cnt <= pix_cnt + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state and datapath enables; a line edge outranks the pixel in that cycle.
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_add   = 1'b0;
        dark_ld   = 1'b0;
        act_take  = 1'b0;
        short_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_WAIT_LINE;
            end
            ST_WAIT_LINE: begin
                if (sh_rise) begin
                    state_nxt = ST_DARK;
                    acc_clr   = 1'b1;
                end
            end
            ST_DARK: begin
                if (sh_rise) begin
                    acc_clr   = 1'b1;
                    short_set = 1'b1;
                end else if (s_tvalid) begin
                    acc_add = (pix_cnt >= OB_FIRST) && (pix_cnt < OB_END);
                    if (pix_cnt == DARK_LAST) begin
                        dark_ld   = 1'b1;
                        state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (sh_rise) begin
                    state_nxt = ST_DARK;
                    acc_clr   = 1'b1;
                    short_set = 1'b1;
                end else if (s_tvalid) begin
                    act_take = 1'b1;
                    if (pix_cnt == ACT_LAST) state_nxt = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (sh_rise) begin
                    state_nxt = en ? ST_DARK : ST_IDLE;
                    acc_clr   = en;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign acc_sum   = acc + {{OB_LOG2{1'b0}}, s_tdata};
    assign acc_total = acc_add ? acc_sum : acc;

    // Optical-black accumulation and dark-level capture.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            acc        <= '0;
            dark_level <= '0;
        end else begin
            if (acc_clr)      acc <= '0;
            else if (acc_add) acc <= acc_sum;
            if (dark_ld)      dark_level <= acc_total[ACC_W-1:OB_LOG2];
        end
    end

    // Stage 1: register the active pixel with its first/last markers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_user  <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= act_take;
            if (act_take) begin
                s1_data <= s_tdata;
                s1_user <= (pix_cnt == ACT_FIRST);
                s1_last <= (pix_cnt == ACT_LAST);
            end
        end
    end

    // Stage 2: subtract with a borrow bit, clamp to zero, write unless full.
    assign diff    = {1'b0, s1_data} - {1'b0, dark_level};
    assign clamped = diff[D_WIDTH] ? '0 : diff[D_WIDTH-1:0];
    assign wr_word = {s1_user, s1_last, clamped};
    assign fifo_wr = s1_valid && !fifo_full;
    assign ovf_set = s1_valid && fifo_full;

    // Line counter (counts tlast even when dropped) and sticky flags; set beats clear.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            line_cnt   <= '0;
            ovf_flag   <= 1'b0;
            short_flag <= 1'b0;
        end else begin
            if (s1_valid && s1_last) line_cnt <= line_cnt + 1'b1;
            if (ovf_set)             ovf_flag <= 1'b1;
            else if (clr_flags)      ovf_flag <= 1'b0;
            if (short_set)           short_flag <= 1'b1;
            else if (clr_flags)      short_flag <= 1'b0;
        end
    end

    ccd_fmt_fifo #(
        .WIDTH (WORD_W),
        .LOG2  (FIFO_LOG2)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (fifo_wr),
        .wr_data (wr_word),
        .rd_en   (m_axis_tready),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Gate the head word with empty so reset forces the sideband to 0 at once.
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : rd_word[D_WIDTH-1:0];
    assign m_axis_tlast  = !fifo_empty && rd_word[tlast_bit(D_WIDTH)];
    assign m_axis_tuser  = !fifo_empty && rd_word[tuser_bit(D_WIDTH)];

endmodule

// File: tb/tb_ccd_line_formatter.sv
// Scoreboard bench for ccd_line_formatter: line drivers push the expected
// output words, a negedge monitor pops and compares on every transfer.
module tb_ccd_line_formatter;
    import ccd_fmt_pkg::*;

    localparam int DW   = DEF_D_WIDTH;
    localparam int SAMP = DEF_SAMP_NUM;
    localparam int ALL  = 100000;

    typedef struct packed {
        logic          user;
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst, en, clr_flags, sh, s_tvalid, m_axis_tready;
    logic [DW-1:0] s_tdata;
    logic [DW-1:0] m_axis_tdata, dark_level;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser, ovf_flag, short_flag;
    logic [15:0]   line_cnt;

    word_t exp_q[$];
    word_t got_w, exp_w;
    int    n_vec = 0;
    int    n_err = 0;
    logic  rand_ready = 1'b0;

    ccd_line_formatter dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .en            (en),
        .clr_flags     (clr_flags),
        .sh            (sh),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .dark_level    (dark_level),
        .line_cnt      (line_cnt),
        .ovf_flag      (ovf_flag),
        .short_flag    (short_flag)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Test pattern: OB samples, a ramp over the active region, 0xFFF elsewhere.
    function automatic logic [DW-1:0] pix_val(input int i, input int ob_mode, input int base);
        if (i >= 16 && i < 24)    return (ob_mode == 0) ? DW'(100) : DW'(96 + i - 16);
        if (i >= 32 && i < 2080)  return DW'(base + i - 32);
        return 12'hFFF;
    endfunction

    function automatic int dark_of(input int ob_mode);
        int sum = 0;
        for (int i = 16; i < 24; i++) sum += int'(pix_val(i, ob_mode, 0));
        return sum >> 3;
    endfunction

    task automatic sample(input logic [DW-1:0] v, input int gap);
        s_tvalid = 1'b1;
        s_tdata  = v;
        tick();
        s_tvalid = 1'b0;
        for (int g = 1; g < gap; g++) tick();
    endtask

    // One line: sh pulse, then samples 0..stop_at-1; expected words pushed up to push_max.
    task automatic drive_line(input int ob_mode, input int base, input int stop_at,
                              input int gap, input int push_max, input int en_off_at);
        int            dark;
        int            pushed;
        logic [DW-1:0] v;
        word_t         w;
        dark   = dark_of(ob_mode);
        pushed = 0;
        sh       = 1'b1;
        s_tvalid = 1'b0;
        tick();
        sh = 1'b0;
        for (int i = 0; i < stop_at; i++) begin
            v = pix_val(i, ob_mode, base);
            if (i == en_off_at) en = 1'b0;
            if (i >= 32 && i < 2080 && pushed < push_max) begin
                w.data = (int'(v) > dark) ? DW'(int'(v) - dark) : '0;
                w.user = (i == 32);
                w.last = (i == 2079);
                exp_q.push_back(w);
                pushed++;
            end
            sample(v, gap);
        end
        repeat (4) tick();
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 20000) begin
            tick();
            c++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: a word transfers on the next posedge when valid and ready are high.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && m_axis_tvalid && m_axis_tready) begin
                got_w = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", got_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("word", got_w, exp_w);
                end
            end
        end
    end

    // Random 50% tready when enabled.
    initial begin
        forever begin
            @(posedge sys_clk);
            #2;
            if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        sys_rst = 1'b1; en = 1'b0; clr_flags = 1'b0; sh = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; m_axis_tready = 1'b1;
        repeat (3) tick();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_line_cnt", line_cnt, 0);
        check("rst_dark", dark_level, 0);
        check("rst_flags", {ovf_flag, short_flag}, 0);
        sys_rst = 1'b0;
        en = 1'b1;
        repeat (3) tick();

        // Flat OB of 100, ramp 100..2147 -> words 0..2047.
        drive_line(0, 100, SAMP, 1, ALL, -1);
        wait_drain("line1_drain");
        check("line1_dark", dark_level, 100);
        check("line1_cnt", line_cnt, 1);

        // OB 96..103 -> dark 99; pixels below dark clamp to 0.
        drive_line(1, 50, SAMP, 1, ALL, -1);
        wait_drain("line2_drain");
        check("line2_dark", dark_level, 99);
        check("line2_cnt", line_cnt, 2);

        // Line cut short at index 1000, then a full line.
        drive_line(0, 100, 1000, 1, ALL, -1);
        drive_line(0, 100, SAMP, 1, ALL, -1);
        wait_drain("short_drain");
        check("short_flag_set", short_flag, 1);
        check("short_cnt", line_cnt, 3);
        check("short_no_ovf", ovf_flag, 0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("short_flag_clr", short_flag, 0);

        // Stalled sink for a whole line: only 16 words survive.
        m_axis_tready = 1'b0;
        drive_line(0, 100, SAMP, 1, 16, -1);
        check("stall_ovf", ovf_flag, 1);
        check("stall_cnt", line_cnt, 4);
        check("stall_tvalid", m_axis_tvalid, 1);
        m_axis_tready = 1'b1;
        wait_drain("stall_drain");
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("ovf_clr", ovf_flag, 0);

        // Random tready, 3 lines at 1/4 pixel rate; en drops mid third line.
        rand_ready = 1'b1;
        drive_line(0, 100, SAMP, 4, ALL, -1);
        drive_line(1, 50, SAMP, 4, ALL, -1);
        drive_line(0, 100, SAMP, 4, ALL, 1000);
        drive_line(0, 100, SAMP, 1, 0, -1);
        wait_drain("rand_drain");
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        check("rand_cnt", line_cnt, 7);
        check("rand_no_ovf", ovf_flag, 0);

        // Reset in the middle of ACTIVE with a full FIFO.
        en = 1'b1;
        repeat (3) tick();
        m_axis_tready = 1'b0;
        drive_line(0, 100, 500, 1, 16, -1);
        check("pre_rst_tvalid", m_axis_tvalid, 1);
        check("pre_rst_tuser", m_axis_tuser, 1);
        sys_rst = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_tuser", m_axis_tuser, 0);
        check("mid_rst_tlast", m_axis_tlast, 0);
        check("mid_rst_cnt", line_cnt, 0);
        check("mid_rst_dark", dark_level, 0);
        check("mid_rst_flags", {ovf_flag, short_flag}, 0);
        repeat (2) tick();
        sys_rst = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 500; i < SAMP; i++) sample(pix_val(i, 0, 100), 1);
        repeat (4) tick();
        check("post_rst_idle", m_axis_tvalid, 0);
        drive_line(0, 100, SAMP, 1, ALL, -1);
        wait_drain("post_rst_drain");
        check("post_rst_cnt", line_cnt, 1);
        check("post_rst_dark", dark_level, 100);

        repeat (20) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
